// File: rtl/box_filter_pkg.sv
// Shared types for the box-filter level-crossing event detector.
// Defines the detector FSM states, the packed event record and its width.
// Pure declarations; no logic, no latency, no flow control.
package box_filter_pkg;

    localparam int DATA_W = 32;
    localparam int TS_W   = 16;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_ARM_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_ARM_LOW  = 2'd3
    } det_state_t;

    // One detected crossing: direction, the sample that completed the
    // debounce, and that sample's timestamp.
    typedef struct packed {
        logic              rising;
        logic [DATA_W-1:0] value;
        logic [TS_W-1:0]   ts;
    } event_t;

    localparam int EVENT_W = $bits(event_t);

    // Debounced level seen outside: high while settled high or arming to fall.
    function automatic logic state_level(det_state_t s);
        return (s == ST_HIGH) || (s == ST_ARM_LOW);
    endfunction

endpackage

// File: rtl/box_filter_event_detect_if.sv
// Bundle of sample input, thresholds, event drain handshake and status.
// No latency of its own; slave = detector, master = sample source / consumer.
// Event side is valid/ready: the consumer holds evt_ready low to stall.
interface box_filter_event_detect_if;
    import box_filter_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] thr_high;
    logic [DATA_W-1:0] thr_low;
    logic              evt_valid;
    logic              evt_ready;
    logic              evt_rising;
    logic [DATA_W-1:0] evt_value;
    logic [TS_W-1:0]   evt_time;
    logic              level;
    logic              overflow;
    logic              clear_overflow;

    modport master (
        output in_valid, in_data, thr_high, thr_low, evt_ready, clear_overflow,
        input  evt_valid, evt_rising, evt_value, evt_time, level, overflow
    );

    modport slave (
        input  in_valid, in_data, thr_high, thr_low, evt_ready, clear_overflow,
        output evt_valid, evt_rising, evt_value, evt_time, level, overflow
    );

endinterface

// File: rtl/event_fifo.sv
// Generic synchronous FIFO, registered storage, head shown first-word-fall-through.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pop only when pop_vld_o && pop_rdy_i; push on full is dropped
// unless a pop happens in the same cycle.
// Ports: clk/rst_n; push_i/push_dat_i write side; full_o/empty_o status;
//        pop_vld_o/pop_rdy_i/pop_dat_o read side.
module event_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     push_dat_i,
    output logic full_o,
    output logic empty_o,
    output logic pop_vld_o,
    input  logic pop_rdy_i,
    output T     pop_dat_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push;
    logic           do_pop;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign pop_vld_o = !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_vld_o && pop_rdy_i;
    // A pop frees the slot the write lands in, so full+push+pop loses nothing.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/box_filter_event_detect.sv
// Hysteresis + debounce level-crossing detector producing timestamped events.
// Latency: event and level appear the cycle after the completing sample.
// Backpressure: events queue in a FIFO drained by valid/ready; when full with
// no pop the new event is dropped and sticky overflow is set.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries samples,
//        thresholds, event handshake/data, level, overflow and its clear.
module box_filter_event_detect
    import box_filter_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4,
    // Must match the package timestamp width carried inside event_t.
    parameter int TS_WIDTH    = TS_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    box_filter_event_detect_if.slave    bus
);

    // cnt only ever holds 0..HOLD_CYCLES-1: reaching HOLD_CYCLES completes.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    det_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                level_q, level_d;
    logic                overflow_q, overflow_d;

    logic                above;
    logic                below;
    logic                push;
    logic                push_rising;
    event_t              push_evt;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_vld;
    event_t              fifo_head;
    event_t              head_evt;

    // Strict compares: a sample equal to a threshold never qualifies.
    assign above = bus.in_data > bus.thr_high;
    assign below = bus.in_data < bus.thr_low;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        push        = 1'b0;
        push_rising = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                ST_LOW: begin
                    if (above) begin
                        if (HOLD_CYCLES == 1) begin
                            state_d     = ST_HIGH;
                            cnt_d       = '0;
                            push        = 1'b1;
                            push_rising = 1'b1;
                        end else begin
                            state_d = ST_ARM_HIGH;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_ARM_HIGH: begin
                    if (!above) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d     = ST_HIGH;
                        cnt_d       = '0;
                        push        = 1'b1;
                        push_rising = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (below) begin
                        if (HOLD_CYCLES == 1) begin
                            state_d = ST_LOW;
                            cnt_d   = '0;
                            push    = 1'b1;
                        end else begin
                            state_d = ST_ARM_LOW;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_ARM_LOW: begin
                    if (!below) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                        push    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        level_d  = state_level(state_d);
        push_evt = '{rising: push_rising, value: bus.in_data, ts: ts_q};
    end

    // ---------------- timestamp and overflow ----------------
    always_comb begin
        ts_d = bus.in_valid ? ts_q + 1'b1 : ts_q;
        // A drop in the same cycle as a clear keeps the flag set.
        if (push && fifo_full && !(fifo_vld && bus.evt_ready)) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- event queue ----------------
    event_fifo #(
        .T     (event_t),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_evt),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .pop_vld_o  (fifo_vld),
        .pop_rdy_i  (bus.evt_ready),
        .pop_dat_o  (fifo_head)
    );

    // Storage is not reset, so the data outputs read zero whenever empty.
    assign head_evt = fifo_empty ? '0 : fifo_head;

    assign bus.evt_valid  = fifo_vld;
    assign bus.evt_rising = head_evt.rising;
    assign bus.evt_value  = head_evt.value;
    assign bus.evt_time   = head_evt.ts;
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_box_filter_event_detect.sv
module tb_box_filter_event_detect;
    import box_filter_pkg::*;

    localparam int H      = 4;
    localparam int D      = 4;
    localparam logic [31:0] THR_HI = 32'd100;
    localparam logic [31:0] THR_LO = 32'd50;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    box_filter_event_detect_if bus ();

    box_filter_event_detect #(
        .HOLD_CYCLES (H),
        .FIFO_DEPTH  (D),
        .TS_WIDTH    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected FIFO contents, oldest first.
    event_t exp_q[$];
    logic        m_level;
    int          m_run;
    logic [15:0] m_ts;
    logic        m_ovf;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 1'b0;
        m_run   = 0;
        m_ts    = '0;
        m_ovf   = 1'b0;
    endtask

    // Run-length model: count consecutive qualifying samples toward a flip.
    task automatic model_sample(input logic [31:0] v, output logic push, output event_t e);
        push = 1'b0;
        e    = '0;
        if (!m_level) begin
            if (v > THR_HI) begin
                m_run++;
                if (m_run == H) begin
                    push = 1'b1;
                    e = '{rising: 1'b1, value: v, ts: m_ts};
                    m_level = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (v < THR_LO) begin
                m_run++;
                if (m_run == H) begin
                    push = 1'b1;
                    e = '{rising: 1'b0, value: v, ts: m_ts};
                    m_level = 1'b0;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ".valid"}, 64'(bus.evt_valid), 64'(exp_q.size() != 0));
        chk({tag, ".level"}, 64'(bus.level), 64'(m_level));
        chk({tag, ".ovf"},   64'(bus.overflow), 64'(m_ovf));
        if (exp_q.size() != 0) begin
            chk({tag, ".rising"}, 64'(bus.evt_rising), 64'(exp_q[0].rising));
            chk({tag, ".value"},  64'(bus.evt_value),  64'(exp_q[0].value));
            chk({tag, ".time"},   64'(bus.evt_time),   64'(exp_q[0].ts));
        end else begin
            chk({tag, ".value0"}, 64'(bus.evt_value), 64'd0);
            chk({tag, ".time0"},  64'(bus.evt_time),  64'd0);
        end
    endtask

    // One clock: drive inputs, update the model, then check after the edge.
    task automatic cyc(input logic vld, input logic [31:0] v, input logic rdy,
                       input logic clr, input string tag);
        logic   push;
        logic   popped;
        logic   drop;
        event_t e;
        bus.in_valid       = vld;
        bus.in_data        = v;
        bus.evt_ready      = rdy;
        bus.clear_overflow = clr;
        popped = rdy && (exp_q.size() != 0);
        push = 1'b0;
        e = '0;
        if (vld) model_sample(v, push, e);
        if (popped) void'(exp_q.pop_front());
        drop = push && (exp_q.size() == D);
        if (push && !drop) exp_q.push_back(e);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid       = 1'b0;
        bus.evt_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        check_outputs(tag);
    endtask

    task automatic samples(input logic [31:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, v, 1'b0, 1'b0, tag);
    endtask

    // Pop until empty, bounded; returns how many events were taken.
    task automatic drain(input string tag, output int taken);
        taken = 0;
        for (int i = 0; i < 2 * D && bus.evt_valid; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, tag);
            taken++;
        end
    endtask

    initial begin
        int taken;
        rst_n              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.thr_high       = THR_HI;
        bus.thr_low        = THR_LO;
        bus.evt_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.rising", 64'(bus.evt_rising), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: four samples above threshold give one rising event at ts 3.
        samples(32'd101, 3, "t1.arm");
        chk("t1.novalid", 64'(bus.evt_valid), 64'd0);
        samples(32'd101, 1, "t1.done");
        chk("t1.valid", 64'(bus.evt_valid), 64'd1);
        chk("t1.value", 64'(bus.evt_value), 64'd101);
        chk("t1.time",  64'(bus.evt_time),  64'd3);
        chk("t1.level", 64'(bus.level),     64'd1);
        drain("t1.pop", taken);
        chk("t1.count", 64'(taken), 64'd1);

        // Back to LOW for the next step.
        samples(32'd49, 4, "t1.fall");
        drain("t1.pop2", taken);
        // ts now 8.

        // 2: an interrupted run and samples equal to thr_high never fire.
        samples(32'd101, 2, "t2.a");
        samples(32'd100, 1, "t2.eq");
        samples(32'd101, 1, "t2.b");
        chk("t2.noevt", 64'(bus.evt_valid), 64'd0);
        samples(32'd100, 4, "t2.eq4");
        samples(32'd101, 3, "t2.c");
        chk("t2.level0", 64'(bus.level), 64'd0);
        samples(32'd101, 1, "t2.d");
        chk("t2.time", 64'(bus.evt_time), 64'd19);
        drain("t2.pop", taken);

        // 3: idle cycles hold the debounce count; event time is the 4th 49.
        samples(32'd49, 2, "t3.a");
        repeat (3) cyc(1'b0, 32'd49, 1'b0, 1'b0, "t3.gap");
        chk("t3.level1", 64'(bus.level), 64'd1);
        samples(32'd49, 2, "t3.b");
        chk("t3.rising", 64'(bus.evt_rising), 64'd0);
        chk("t3.time",   64'(bus.evt_time),   64'd23);
        chk("t3.level0", 64'(bus.level),      64'd0);
        drain("t3.pop", taken);

        // 4: five crossings with the consumer stalled: fifth is dropped.
        samples(32'd101, 4, "t4.r1");
        samples(32'd49,  4, "t4.f1");
        samples(32'd101, 4, "t4.r2");
        samples(32'd49,  4, "t4.f2");
        chk("t4.ovf0", 64'(bus.overflow), 64'd0);
        samples(32'd101, 4, "t4.r3");
        chk("t4.ovf1",   64'(bus.overflow), 64'd1);
        chk("t4.level",  64'(bus.level),    64'd1);
        chk("t4.stable", 64'(bus.evt_time), 64'd27);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, "t4.clear");
        chk("t4.cleared", 64'(bus.overflow), 64'd0);

        // 5: full FIFO, push and pop in the same cycle: nothing dropped.
        samples(32'd49, 3, "t5.arm");
        cyc(1'b1, 32'd49, 1'b1, 1'b0, "t5.pushpop");
        chk("t5.ovf", 64'(bus.overflow), 64'd0);
        drain("t5.drain", taken);
        chk("t5.count", 64'(taken), 64'd4);

        // 6: async reset mid-arm with two events queued.
        samples(32'd101, 4, "t6.r");
        samples(32'd49,  4, "t6.f");
        samples(32'd101, 2, "t6.arm");
        chk("t6.queued", 64'(exp_q.size()), 64'(bus.evt_valid ? 2 : 0));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6.rst_valid", 64'(bus.evt_valid), 64'd0);
        chk("t6.rst_level", 64'(bus.level),     64'd0);
        chk("t6.rst_value", 64'(bus.evt_value), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs("t6.after");
        samples(32'd101, 4, "t6.rise");
        chk("t6.time",  64'(bus.evt_time),  64'd3);
        chk("t6.valid", 64'(bus.evt_valid), 64'd1);
        drain("t6.pop", taken);
        chk("t6.count", 64'(taken), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
